// File: rtl/ff_response_checker_if.sv
// Observation bus between a flip-flop under test harness and its response checker.
// The checker connects through the slave modport; the stimulus side uses master.
interface ff_response_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             d_obs;
    logic             q_obs;
    logic [CNT_W-1:0] check_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic             init_ok;
    logic             fail;
    logic [1:0]       state;

    modport master (
        output en, clr, d_obs, q_obs,
        input  check_cnt, err_cnt, first_err_idx, init_ok, fail, state
    );

    modport slave (
        input  en, clr, d_obs, q_obs,
        output check_cnt, err_cnt, first_err_idx, init_ok, fail, state
    );
endinterface

// File: rtl/ff_response_checker.sv
// Checks that a flip-flop's Q follows its D after LAT enabled edges, counts
// comparisons and mismatches, and verifies the post-reset initial value.
module ff_response_checker #(
    parameter logic        INIT_VAL    = 1'b0,
    parameter int unsigned LAT         = 1,
    parameter int unsigned CNT_W       = 8,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    ff_response_checker_if.slave bus
);
    localparam int unsigned FC_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [LAT-1:0]   hist_q, hist_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic             init_ok_q, init_ok_d;
    logic             fail_q, fail_d;
    logic             init_done_q, init_done_d;
    logic             mismatch_c;
    logic [LAT:0]     hist_ext_c;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            hist_q          <= {LAT{INIT_VAL}};
            fc_q            <= '0;
            check_cnt_q     <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
            init_ok_q       <= 1'b0;
            fail_q          <= 1'b0;
            init_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            hist_q          <= hist_d;
            fc_q            <= fc_d;
            check_cnt_q     <= check_cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            init_ok_q       <= init_ok_d;
            fail_q          <= fail_d;
            init_done_q     <= init_done_d;
        end
    end

    // Next-state: priming, checking, halt, then clear and one-shot init check on top
    always_comb begin
        state_d         = state_q;
        hist_d          = hist_q;
        fc_d            = fc_q;
        check_cnt_d     = check_cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        init_ok_d       = init_ok_q;
        fail_d          = fail_q;
        init_done_d     = init_done_q;
        mismatch_c      = 1'b0;
        // Low LAT bits of {hist, d} are the shifted history for any LAT, including 1
        hist_ext_c      = {hist_q, bus.d_obs};

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    hist_d  = hist_ext_c[LAT-1:0];
                    fc_d    = FC_W'(1);
                    state_d = (LAT == 1) ? CHECK : PRIME;
                end
            end
            PRIME: begin
                if (bus.en) begin
                    hist_d = hist_ext_c[LAT-1:0];
                    fc_d   = fc_q + FC_W'(1);
                    if (fc_d == FC_W'(LAT)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (bus.en) begin
                    mismatch_c = (bus.q_obs != hist_q[LAT-1]);
                    hist_d     = hist_ext_c[LAT-1:0];
                    if (check_cnt_q != CNT_MAX) begin
                        check_cnt_d = check_cnt_q + CNT_W'(1);
                    end
                    if (mismatch_c) begin
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (err_cnt_q == '0) begin
                            first_err_idx_d = check_cnt_q;
                        end
                        fail_d = 1'b1;
                        if (STOP_ON_ERR) begin
                            state_d = HALT;
                        end
                    end
                end
            end
            default: begin
            end
        endcase

        if (bus.clr) begin
            state_d         = IDLE;
            hist_d          = {LAT{INIT_VAL}};
            fc_d            = '0;
            check_cnt_d     = '0;
            err_cnt_d       = '0;
            first_err_idx_d = '0;
            fail_d          = 1'b0;
        end

        // The init check fires on the first edge after reset even alongside clr
        if (!init_done_q) begin
            init_done_d = 1'b1;
            init_ok_d   = (bus.q_obs == INIT_VAL);
            if (bus.q_obs != INIT_VAL) begin
                fail_d = 1'b1;
            end
        end
    end

    assign bus.state         = state_q;
    assign bus.check_cnt     = check_cnt_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_idx = first_err_idx_q;
    assign bus.init_ok       = init_ok_q;
    assign bus.fail          = fail_q;
endmodule

// File: tb/tb_ff_response_checker.sv
// Directed bench for ff_response_checker across several parameter sets.
`timescale 1ns/1ps
module tb_ff_response_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [3:0]  dseq4;
    logic [7:0]  dv8;
    logic        qm;

    always #5 clk = ~clk;

    ff_response_checker_if #(.CNT_W(8)) if_def   ();
    ff_response_checker_if #(.CNT_W(8)) if_halt  ();
    ff_response_checker_if #(.CNT_W(8)) if_lat3  ();
    ff_response_checker_if #(.CNT_W(8)) if_init1 ();
    ff_response_checker_if #(.CNT_W(2)) if_sat   ();

    ff_response_checker #(.INIT_VAL(1'b0), .LAT(1), .CNT_W(8), .STOP_ON_ERR(1'b0)) u_def (
        .clk(clk), .rst_n(rst_n), .bus(if_def.slave));
    ff_response_checker #(.INIT_VAL(1'b0), .LAT(1), .CNT_W(8), .STOP_ON_ERR(1'b1)) u_halt (
        .clk(clk), .rst_n(rst_n), .bus(if_halt.slave));
    ff_response_checker #(.INIT_VAL(1'b0), .LAT(3), .CNT_W(8), .STOP_ON_ERR(1'b0)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(if_lat3.slave));
    ff_response_checker #(.INIT_VAL(1'b1), .LAT(1), .CNT_W(8), .STOP_ON_ERR(1'b0)) u_init1 (
        .clk(clk), .rst_n(rst_n), .bus(if_init1.slave));
    ff_response_checker #(.INIT_VAL(1'b0), .LAT(1), .CNT_W(2), .STOP_ON_ERR(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(if_sat.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        if_def.en   = 1'b0; if_def.clr   = 1'b0; if_def.d_obs   = 1'b0; if_def.q_obs   = 1'b0;
        if_halt.en  = 1'b0; if_halt.clr  = 1'b0; if_halt.d_obs  = 1'b0; if_halt.q_obs  = 1'b0;
        if_lat3.en  = 1'b0; if_lat3.clr  = 1'b0; if_lat3.d_obs  = 1'b0; if_lat3.q_obs  = 1'b0;
        if_init1.en = 1'b0; if_init1.clr = 1'b0; if_init1.d_obs = 1'b0; if_init1.q_obs = 1'b0;
        if_sat.en   = 1'b0; if_sat.clr   = 1'b0; if_sat.d_obs   = 1'b0; if_sat.q_obs   = 1'b0;
    endtask

    // Holds reset across one edge; caller sets init-edge inputs and releases rst_n
    task automatic hold_reset();
        rst_n = 1'b0;
        zero_inputs();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        tick();
        tick();
        check("rst_state",   32'(if_def.state), 32'd0);
        check("rst_chk_cnt", 32'(if_def.check_cnt), 32'd0);
        check("rst_err_cnt", 32'(if_def.err_cnt), 32'd0);
        check("rst_init_ok", 32'(if_def.init_ok), 32'd0);
        check("rst_fail",    32'(if_def.fail), 32'd0);

        // Default params, q is d delayed one edge, d = 0,1,0,1
        dseq4 = 4'b1010;
        qm = 1'b0;
        if_def.en = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if_def.d_obs = dseq4[k];
            if_def.q_obs = qm;
            tick();
            qm = dseq4[k];
            if (k == 0) begin
                check("a_state_e1",   32'(if_def.state), 32'd2);
                check("a_init_ok_e1", 32'(if_def.init_ok), 32'd1);
            end
        end
        check("a_chk_cnt", 32'(if_def.check_cnt), 32'd3);
        check("a_err_cnt", 32'(if_def.err_cnt), 32'd0);
        check("a_fail",    32'(if_def.fail), 32'd0);

        // Forced mismatch at the third check, no stop
        hold_reset();
        if_def.en = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if_def.d_obs = 1'b0;
            if_def.q_obs = (k == 4);
            tick();
            if (k == 4) begin
                check("b_err_cnt_e4", 32'(if_def.err_cnt), 32'd1);
                check("b_first_idx",  32'(if_def.first_err_idx), 32'd2);
                check("b_fail",       32'(if_def.fail), 32'd1);
            end
        end
        check("b_chk_cnt_e6", 32'(if_def.check_cnt), 32'd5);
        check("b_err_cnt_e6", 32'(if_def.err_cnt), 32'd1);
        check("b_state_e6",   32'(if_def.state), 32'd2);

        // Same stimulus with stop-on-error: halt, freeze, then clr
        hold_reset();
        if_halt.en = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if_halt.d_obs = 1'b0;
            if_halt.q_obs = (k == 4);
            tick();
        end
        check("c_state_halt", 32'(if_halt.state), 32'd3);
        check("c_chk_cnt",    32'(if_halt.check_cnt), 32'd3);
        check("c_err_cnt",    32'(if_halt.err_cnt), 32'd1);
        check("c_first_idx",  32'(if_halt.first_err_idx), 32'd2);
        for (int k = 0; k < 4; k++) begin
            if_halt.en    = k[0];
            if_halt.d_obs = ~k[0];
            if_halt.q_obs = k[0];
            tick();
        end
        check("c_frz_state",   32'(if_halt.state), 32'd3);
        check("c_frz_chk_cnt", 32'(if_halt.check_cnt), 32'd3);
        check("c_frz_err_cnt", 32'(if_halt.err_cnt), 32'd1);
        if_halt.en  = 1'b1;
        if_halt.clr = 1'b1;
        tick();
        if_halt.clr = 1'b0;
        if_halt.en  = 1'b0;
        check("c_clr_state",   32'(if_halt.state), 32'd0);
        check("c_clr_chk_cnt", 32'(if_halt.check_cnt), 32'd0);
        check("c_clr_err_cnt", 32'(if_halt.err_cnt), 32'd0);
        check("c_clr_first",   32'(if_halt.first_err_idx), 32'd0);
        check("c_clr_fail",    32'(if_halt.fail), 32'd0);
        check("c_clr_init_ok", 32'(if_halt.init_ok), 32'd1);

        // LAT=3, q is d delayed three enabled edges, with an en=0 gap
        dv8 = 8'b0100_1101;
        hold_reset();
        if_lat3.en = 1'b1;
        rst_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            if_lat3.d_obs = dv8[n-1];
            if_lat3.q_obs = (n > 3) ? dv8[n-4] : 1'b0;
            tick();
            if (n == 1) check("d_state_e1", 32'(if_lat3.state), 32'd1);
            if (n == 2) check("d_state_e2", 32'(if_lat3.state), 32'd1);
            if (n == 3) check("d_state_e3", 32'(if_lat3.state), 32'd2);
        end
        check("d_chk_cnt_e5", 32'(if_lat3.check_cnt), 32'd2);
        if_lat3.en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if_lat3.d_obs = 1'($urandom_range(1));
            if_lat3.q_obs = 1'($urandom_range(1));
            tick();
        end
        check("d_gap_state",   32'(if_lat3.state), 32'd2);
        check("d_gap_chk_cnt", 32'(if_lat3.check_cnt), 32'd2);
        check("d_gap_err_cnt", 32'(if_lat3.err_cnt), 32'd0);
        check("d_gap_fail",    32'(if_lat3.fail), 32'd0);
        if_lat3.en = 1'b1;
        for (int n = 6; n <= 8; n++) begin
            if_lat3.d_obs = dv8[n-1];
            if_lat3.q_obs = dv8[n-4];
            tick();
        end
        check("d_chk_cnt_e8", 32'(if_lat3.check_cnt), 32'd5);
        check("d_err_cnt_e8", 32'(if_lat3.err_cnt), 32'd0);
        check("d_fail_e8",    32'(if_lat3.fail), 32'd0);

        // INIT_VAL=1 with q=0 at the init edge, then clr
        hold_reset();
        if_init1.q_obs = 1'b0;
        rst_n = 1'b1;
        tick();
        check("e_init_ok", 32'(if_init1.init_ok), 32'd0);
        check("e_fail",    32'(if_init1.fail), 32'd1);
        if_init1.clr = 1'b1;
        tick();
        if_init1.clr = 1'b0;
        check("e_clr_fail",    32'(if_init1.fail), 32'd0);
        check("e_clr_init_ok", 32'(if_init1.init_ok), 32'd0);

        // CNT_W=2 saturation, then asynchronous reset between edges
        hold_reset();
        if_sat.en = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if_sat.d_obs = 1'b0;
            if_sat.q_obs = (k >= 2);
            tick();
        end
        check("f_chk_cnt_sat", 32'(if_sat.check_cnt), 32'd3);
        check("f_err_cnt_sat", 32'(if_sat.err_cnt), 32'd3);
        check("f_first_idx",   32'(if_sat.first_err_idx), 32'd0);
        check("f_fail",        32'(if_sat.fail), 32'd1);
        check("f_state",       32'(if_sat.state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_arst_state",   32'(if_sat.state), 32'd0);
        check("f_arst_chk_cnt", 32'(if_sat.check_cnt), 32'd0);
        check("f_arst_err_cnt", 32'(if_sat.err_cnt), 32'd0);
        check("f_arst_first",   32'(if_sat.first_err_idx), 32'd0);
        check("f_arst_fail",    32'(if_sat.fail), 32'd0);
        check("f_arst_init_ok", 32'(if_sat.init_ok), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
